des_perm_pipe: RTL and testbench
================================

Name: des_perm_pipe

Overview:
- Parametrised successor to the single-purpose DES final-permutation register.
- Applies a per-transaction selectable DES bit permutation to a 64-bit block: IP, IP^-1 (FP) or bypass.
- Carries the result through a configurable-depth pipeline with valid/ready backpressure and a sideband tag.
- Sits between the block input/key-schedule front end and the round core, and between the round core and the output interface.

Parameters:
- STAGES, 1, number of register stages (>=1); unstalled latency in cycles.
- TAG_W, 4, width of the sideband tag carried alongside each block (>=1).

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- flush_in  input  1  synchronous clear of all in-flight blocks.
- data_in  input  64  input block; DES bit n (1..64) is data_in[64-n].
- mode_in  input  2  00 = IP, 01 = FP (IP^-1), 10 = bypass, 11 = reserved.
- tag_in  input  TAG_W  sideband, travels with the block unchanged.
- data_in_valid  input  1  upstream has a block.
- data_in_ready  output  1  block accepted when valid && ready.
- data_out  output  64  permuted block.
- tag_out  output  TAG_W  tag of data_out.
- mode_err_out  output  1  block was issued with mode 11.
- data_out_valid  output  1  data_out holds a block.
- data_out_ready  input  1  downstream accepts.
- occupancy_out  output  $clog2(STAGES+1)  number of valid stages.

Behaviour:
- Reset (async assert, sync release): all stage valids 0; data, tag and err registers 0. Therefore data_out = 0, tag_out = 0, mode_err_out = 0, data_out_valid = 0, occupancy_out = 0. data_in_ready = 1 after reset.
- Permutation is combinational on data_in and captured in stage 0 on accept. Same bit mapping as standard DES tables, MSB = DES bit 1.
  - FP output MSB = DES bit 40, i.e. data_in[24].
  - IP output MSB = DES bit 58, i.e. data_in[6].
- Mode 11: block is passed unpermuted (bypass) and its err bit is set. The err bit travels with the block; it is never dropped.
- Pipeline: stages 0..STAGES-1; stage STAGES-1 drives all outputs.
  - ready[STAGES] = data_out_ready.
  - ready[i] = !valid[i] || ready[i+1].
  - data_in_ready = ready[0].
- A stage loads from its predecessor when ready[i]. Its valid becomes the predecessor's valid; an empty predecessor loads a bubble.
- Bubbles collapse: a stalled output does not block upstream stages that have empty slots ahead.
- Throughput is 1 block/cycle when data_out_ready is held 1. Latency from accept to data_out_valid is exactly STAGES cycles.
- Stall: while data_out_valid && !data_out_ready, data_out, tag_out and mode_err_out hold stable. Blocks are neither lost nor duplicated.
- When a stage is empty, its data registers may hold stale values; data_out is only meaningful while data_out_valid = 1.
- occupancy_out is the count of set stage valids, registered-consistent with the valids in the same cycle.
- flush_in = 1:
  - All valids clear on the next edge.
  - data_in_ready = 0 that cycle, so no accept occurs.
  - Data registers keep their values.
  - Flush has priority over accept and shift in the same cycle.
- Reset mid-operation: all in-flight blocks are discarded immediately; no output pulse occurs on reset release.
- Simultaneous accept and output handshake at full occupancy is legal. Occupancy stays constant and no bubble is inserted.
- Mode and tag are sampled only on accept. Changes while not accepting have no effect.

Test Plan:
- STAGES = 1, mode 00, data_in = 64'h0123456789ABCDEF, tag 3, out_ready = 1 -> next cycle data_out = 64'hCC00CCFFF0AAF0AA, tag_out = 3, valid for 1 cycle.
- Mode 01, data_in = 64'h0A4CD99543423234 -> data_out = 64'h85E813540F0AB405. Then mode 01 on 64'hCC00CCFFF0AAF0AA -> 64'h0123456789ABCDEF (IP/FP round trip).
- STAGES = 3: stream 8 blocks with tags 0..7 and alternating modes 00/01/10 -> outputs appear 3 cycles after accept, in order, 1/cycle, each matching a reference model.
- STAGES = 3, hold data_out_ready = 0 while sending -> exactly 3 accepts, data_in_ready falls to 0, occupancy_out = 3, data_out frozen. Release -> 3 blocks out in order, no loss or duplicate.
- Mode 11 with data_in = 64'hFFFF0000AAAA5555 -> data_out equals the input unchanged, mode_err_out = 1 alongside it. Next mode 00 block has mode_err_out = 0.
- Pipeline full, assert flush_in with data_in_valid = 1 -> no accept that cycle, valids and occupancy 0 next cycle. Repeat with rst_n_in pulsed low mid-stream -> all outputs 0 immediately, no spurious valid after release.

Source files
------------

// File: rtl/des_perm_pipe.sv
// ---------------------------------------------------------------------------
// des_perm_pipe
//   Applies a per-block selectable DES bit permutation (IP, IP^-1 or bypass)
//   to a 64-bit block and carries the result, its sideband tag and a
//   mode-error flag through an elastic pipeline of STAGES register stages
//   with valid/ready backpressure.
//
//   DES numbering: DES bit n (1..64) is vector bit [64-n], so the MSB of every
//   64-bit port is DES bit 1.
//
// Ports
//   clk_in          single clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   flush_in        synchronous clear of every in-flight block
//   data_in         input block
//   mode_in         00 = IP, 01 = FP (IP^-1), 10 = bypass, 11 = reserved
//   tag_in          sideband carried unchanged with the block
//   data_in_valid   upstream offers a block
//   data_in_ready   block accepted when data_in_valid && data_in_ready
//   data_out        permuted block (meaningful only while data_out_valid)
//   tag_out         tag of data_out
//   mode_err_out    block was issued with the reserved mode
//   data_out_valid  data_out holds a block
//   data_out_ready  downstream accepts
//   occupancy_out   number of valid stages
// ---------------------------------------------------------------------------
module des_perm_pipe #(
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         flush_in,
    input  logic [63:0]                  data_in,
    input  logic [1:0]                   mode_in,
    input  logic [TAG_W-1:0]             tag_in,
    input  logic                         data_in_valid,
    output logic                         data_in_ready,
    output logic [63:0]                  data_out,
    output logic [TAG_W-1:0]             tag_out,
    output logic                         mode_err_out,
    output logic                         data_out_valid,
    input  logic                         data_out_ready,
    output logic [$clog2(STAGES+1)-1:0]  occupancy_out
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    localparam logic [1:0] MODE_IP  = 2'b00;
    localparam logic [1:0] MODE_FP  = 2'b01;
    localparam logic [1:0] MODE_BYP = 2'b10;

    // Standard DES initial permutation: output DES bit k takes input DES bit IP_TAB[k-1].
    localparam int unsigned IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    // Standard DES final permutation (IP^-1).
    localparam int unsigned FP_TAB [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    // Payload held by every pipeline stage.
    typedef struct packed {
        logic             err;
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
    } stage_t;

    stage_t             stage_q [STAGES];
    logic [STAGES-1:0]  valid_q;
    logic [OCC_W-1:0]   occ_q;

    stage_t             in_c;
    logic [63:0]        perm_c;
    logic               mode_err_c;
    logic [STAGES-1:0]  ready_c;
    logic [STAGES-1:0]  valid_d;
    logic [OCC_W-1:0]   occ_d;

    // Input permutation; the reserved mode falls through as bypass with err set.
    always_comb begin
        perm_c     = data_in;
        mode_err_c = 1'b0;
        case (mode_in)
            MODE_IP: begin
                for (int i = 0; i < 64; i++) begin
                    perm_c[6'(63 - i)] = data_in[6'(64 - IP_TAB[i])];
                end
            end
            MODE_FP: begin
                for (int i = 0; i < 64; i++) begin
                    perm_c[6'(63 - i)] = data_in[6'(64 - FP_TAB[i])];
                end
            end
            MODE_BYP: begin
                perm_c = data_in;
            end
            default: begin
                mode_err_c = 1'b1;
            end
        endcase
    end

    always_comb begin
        in_c      = '0;
        in_c.err  = mode_err_c;
        in_c.tag  = tag_in;
        in_c.data = perm_c;
    end

    // Stage i may load when it is empty or everything downstream of it can move.
    // Evaluated as "some stage at or after i is empty" to keep the chain acyclic.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        ready_c  = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            all_full   = all_full & valid_q[i];
            ready_c[i] = !all_full || data_out_ready;
        end
    end

    assign data_in_ready = ready_c[0] && !flush_in;

    // Next stage valids; flush wins over accept and shift.
    always_comb begin
        valid_d = valid_q;
        if (flush_in) begin
            valid_d = '0;
        end else begin
            if (ready_c[0]) begin
                valid_d[0] = data_in_valid;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (ready_c[i]) begin
                    valid_d[i] = valid_q[i-1];
                end
            end
        end
    end

    // Occupancy tracks the valids that will be registered on this edge.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    // Valid and occupancy registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    // Payload registers: only real blocks are written, bubbles leave stale data.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else if (!flush_in) begin
            if (ready_c[0] && data_in_valid) begin
                stage_q[0] <= in_c;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (ready_c[i] && valid_q[i-1]) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end
    end

    assign data_out       = stage_q[STAGES-1].data;
    assign tag_out        = stage_q[STAGES-1].tag;
    assign mode_err_out   = stage_q[STAGES-1].err;
    assign data_out_valid = valid_q[STAGES-1];
    assign occupancy_out  = occ_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
// ---------------------------------------------------------------------------
// tb_des_perm_pipe
//   Self-checking bench. A single-stage and a three-stage instance share the
//   input stimulus. A directed vector table exercises the permutation modes on
//   the single-stage instance; hand-written sequences cover streaming, stall,
//   flush and mid-stream reset on the three-stage instance.
// ---------------------------------------------------------------------------
module tb_des_perm_pipe;

    localparam int unsigned TAG_W = 4;
    localparam int          NV    = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [63:0]       din;
    logic [1:0]        mode;
    logic [TAG_W-1:0]  tag;
    logic              din_valid;
    logic              out_ready;

    logic              r1, e1, v1;
    logic [63:0]       d1;
    logic [TAG_W-1:0]  t1;
    logic [0:0]        occ1;

    logic              r3, e3, v3;
    logic [63:0]       d3;
    logic [TAG_W-1:0]  t3;
    logic [1:0]        occ3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    des_perm_pipe #(.STAGES(1), .TAG_W(TAG_W)) u_dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
        .data_in(din), .mode_in(mode), .tag_in(tag),
        .data_in_valid(din_valid), .data_in_ready(r1),
        .data_out(d1), .tag_out(t1), .mode_err_out(e1),
        .data_out_valid(v1), .data_out_ready(out_ready),
        .occupancy_out(occ1)
    );

    des_perm_pipe #(.STAGES(3), .TAG_W(TAG_W)) u_dut3 (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
        .data_in(din), .mode_in(mode), .tag_in(tag),
        .data_in_valid(din_valid), .data_in_ready(r3),
        .data_out(d3), .tag_out(t3), .mode_err_out(e3),
        .data_out_valid(v3), .data_out_ready(out_ready),
        .occupancy_out(occ3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference IP: input DES bit feeding output DES bit k, from the table's row structure.
    function automatic int ip_src(input int k);
        int r;
        int c;
        r = (k - 1) / 8;
        c = (k - 1) % 8;
        return ((r < 4) ? (58 + 2 * r) : (57 + 2 * (r - 4))) - 8 * c;
    endfunction

    // FP is built as the inverse scatter of IP.
    function automatic logic [63:0] model(input logic [1:0] m, input logic [63:0] d);
        logic [63:0] o;
        o = d;
        if (m == 2'b00) begin
            for (int k = 1; k <= 64; k++) o[64 - k] = d[64 - ip_src(k)];
        end else if (m == 2'b01) begin
            for (int k = 1; k <= 64; k++) o[64 - ip_src(k)] = d[64 - k];
        end
        return o;
    endfunction

    // Edge counter and scoreboard for the three-stage instance.
    typedef struct {
        logic [63:0]      d;
        logic [TAG_W-1:0] t;
        logic             e;
        int               edge_n;
    } exp_t;

    exp_t q[$];
    int   edges      = 0;
    bit   mon_en     = 1'b0;
    bit   lat_chk    = 1'b0;
    bit   acc_flag   = 1'b0;
    bit   front_seen = 1'b0;
    int   n_acc      = 0;
    int   n_out      = 0;

    always @(posedge clk) edges <= edges + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (v3) begin
                chk("s3_out_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    chk("s3_data", d3, q[0].d);
                    chk("s3_tag", 64'(t3), 64'(q[0].t));
                    chk("s3_err", 64'(e3), 64'(q[0].e));
                    if (lat_chk && !front_seen)
                        chk("s3_latency", 64'(edges), 64'(q[0].edge_n + 3));
                    front_seen = 1'b1;
                    if (out_ready) begin
                        void'(q.pop_front());
                        front_seen = 1'b0;
                        n_out++;
                    end
                end
            end
            acc_flag = din_valid && r3;
            if (acc_flag) begin
                q.push_back('{d: model(mode, din), t: tag, e: (mode == 2'b11), edge_n: edges});
                n_acc++;
            end
        end
    end

    typedef struct {
        logic [1:0]       mode;
        logic [63:0]      din;
        logic [TAG_W-1:0] tag;
        logic [63:0]      exp;
        logic             err;
    } vec_t;

    vec_t vecs [NV];

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string nm, input int exp_out);
        for (int c = 0; c < 30 && q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk({nm, "_drained"}, 64'(q.size()), 64'd0);
        chk({nm, "_outputs"}, 64'(n_out), 64'(exp_out));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int blk;
        rst_n = 1'b0; flush = 1'b0; din = '0; mode = 2'b00; tag = '0;
        din_valid = 1'b0; out_ready = 1'b1;

        vecs[0] = '{2'b00, 64'h0123456789ABCDEF, 4'd3,  64'hCC00CCFFF0AAF0AA, 1'b0};
        vecs[1] = '{2'b01, 64'h0A4CD99543423234, 4'd5,  64'h85E813540F0AB405, 1'b0};
        vecs[2] = '{2'b01, 64'hCC00CCFFF0AAF0AA, 4'd6,  64'h0123456789ABCDEF, 1'b0};
        vecs[3] = '{2'b11, 64'hFFFF0000AAAA5555, 4'd9,  64'hFFFF0000AAAA5555, 1'b1};
        vecs[4] = '{2'b00, 64'h0123456789ABCDEF, 4'd1,  64'hCC00CCFFF0AAF0AA, 1'b0};
        vecs[5] = '{2'b10, 64'hDEADBEEFCAFEF00D, 4'd2,  64'hDEADBEEFCAFEF00D, 1'b0};
        vecs[6] = '{2'b00, 64'h0000000000000040, 4'd7,  64'h8000000000000000, 1'b0};
        vecs[7] = '{2'b00, 64'h8000000000000000, 4'd4,  64'h0000000001000000, 1'b0};
        vecs[8] = '{2'b01, 64'h0000000001000000, 4'd10, 64'h8000000000000000, 1'b0};
        vecs[9] = '{2'b01, 64'h0000000000000040, 4'd11, 64'h0000000000000200, 1'b0};

        // Reset values while reset is held.
        #12;
        chk("rst_d1", d1, 64'd0);
        chk("rst_t1", 64'(t1), 64'd0);
        chk("rst_e1", 64'(e1), 64'd0);
        chk("rst_v1", 64'(v1), 64'd0);
        chk("rst_occ1", 64'(occ1), 64'd0);
        chk("rst_d3", d3, 64'd0);
        chk("rst_v3", 64'(v3), 64'd0);
        chk("rst_occ3", 64'(occ3), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready1", 64'(r1), 64'd1);
        chk("rst_ready3", 64'(r3), 64'd1);

        // Directed permutation vectors on the single-stage instance.
        for (int i = 0; i < NV; i++) begin
            mode = vecs[i].mode; din = vecs[i].din; tag = vecs[i].tag; din_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 64'(r1), 64'd1);
            @(posedge clk); #1;
            din_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 64'(v1), 64'd1);
            chk($sformatf("vec%0d_data", i), d1, vecs[i].exp);
            chk($sformatf("vec%0d_tag", i), 64'(t1), 64'(vecs[i].tag));
            chk($sformatf("vec%0d_err", i), 64'(e1), 64'(vecs[i].err));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid_drop", i), 64'(v1), 64'd0);
        end

        // Three-stage streaming: 8 blocks, modes cycling IP/FP/bypass.
        do_reset();
        q.delete(); n_acc = 0; n_out = 0; front_seen = 1'b0;
        out_ready = 1'b1; lat_chk = 1'b1; mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mode = 2'(i % 3);
            din = 64'h0123456789ABCDEF + 64'(i) * 64'h1111111100000101;
            tag = TAG_W'(i);
            din_valid = 1'b1;
            if (i == 5) chk("s3_stream_occ", 64'(occ3), 64'd3);
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        drain("s3_stream", 8);
        chk("s3_stream_accepts", 64'(n_acc), 64'd8);

        // Three-stage stall: downstream blocked while upstream keeps offering.
        mon_en = 1'b0;
        do_reset();
        q.delete(); n_acc = 0; n_out = 0; front_seen = 1'b0;
        out_ready = 1'b0; lat_chk = 1'b0; mon_en = 1'b1;
        blk = 0;
        mode = 2'(blk % 3); din = 64'hFEDCBA9876543210 ^ 64'(blk); tag = TAG_W'(blk + 8);
        din_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (acc_flag) begin
                blk++;
                mode = 2'(blk % 3); din = 64'hFEDCBA9876543210 ^ 64'(blk); tag = TAG_W'(blk + 8);
            end
        end
        chk("stall_accepts", 64'(n_acc), 64'd3);
        chk("stall_ready", 64'(r3), 64'd0);
        chk("stall_occ", 64'(occ3), 64'd3);
        chk("stall_valid", 64'(v3), 64'd1);
        chk("stall_data", d3, model(2'b00, 64'hFEDCBA9876543210));
        chk("stall_tag", 64'(t3), 64'd8);
        din_valid = 1'b0;
        out_ready = 1'b1;
        drain("stall", 3);
        mon_en = 1'b0;

        // Flush with the pipeline full and upstream still offering a block.
        do_reset();
        out_ready = 1'b0; mode = 2'b00; tag = 4'd2;
        for (int b = 0; b < 3; b++) begin
            din = 64'h0123456789ABCDEF ^ (64'(b) << 8);
            din_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush_pre_occ", 64'(occ3), 64'd3);
        chk("flush_pre_valid", 64'(v3), 64'd1);
        flush = 1'b1; out_ready = 1'b1; din = 64'h5555AAAA5555AAAA; din_valid = 1'b1;
        @(negedge clk);
        chk("flush_ready3", 64'(r3), 64'd0);
        chk("flush_ready1", 64'(r1), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; din_valid = 1'b0;
        chk("flush_occ3", 64'(occ3), 64'd0);
        chk("flush_valid3", 64'(v3), 64'd0);
        chk("flush_data_kept", d3, 64'hCC00CCFFF0AAF0AA);
        chk("flush_valid1", 64'(v1), 64'd0);
        chk("flush_occ1", 64'(occ1), 64'd0);
        @(posedge clk); #1;
        chk("flush_no_accept", 64'(v3), 64'd0);

        // Reset asserted mid-stream.
        do_reset();
        out_ready = 1'b1; mode = 2'b01; tag = 4'd5;
        for (int b = 0; b < 3; b++) begin
            din = 64'h0A4CD99543423234 + 64'(b);
            din_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("mid_pre_valid", 64'(v3), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid3", 64'(v3), 64'd0);
        chk("mid_rst_data3", d3, 64'd0);
        chk("mid_rst_tag3", 64'(t3), 64'd0);
        chk("mid_rst_err3", 64'(e3), 64'd0);
        chk("mid_rst_occ3", 64'(occ3), 64'd0);
        chk("mid_rst_data1", d1, 64'd0);
        chk("mid_rst_valid1", 64'(v1), 64'd0);
        din_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst_valid3_c%0d", c), 64'(v3), 64'd0);
            chk($sformatf("post_rst_valid1_c%0d", c), 64'(v1), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
